// File: rtl/ddrx_mc_pkg.sv
`default_nettype none
// ============================================================================
// ddrx_mc_pkg : shared command types for the DDRx controller front-end
// Revision    : 1.0  initial release
// ============================================================================
package ddrx_mc_pkg;

  localparam int C_MC_ADDR_WIDTH = 32;
  localparam int C_MC_ID_WIDTH   = 4;
  localparam int C_MC_PORT_WIDTH = 2;

  typedef enum logic [0:0] {
    ARB_RR   = 1'b0,
    ARB_AGED = 1'b1
  } arb_mode_e;

  // Reference command layout; arbiters rebuild it at their own port widths.
  typedef struct packed {
    logic                       write;
    logic [C_MC_ADDR_WIDTH-1:0] addr;
    logic [C_MC_ID_WIDTH-1:0]   id;
    logic [7:0]                 len;
    logic [C_MC_PORT_WIDTH-1:0] port;
  } cmd_t;

endpackage
`default_nettype wire

// File: rtl/ddrx_cmd_fifo.sv
`default_nettype none
// ============================================================================
// ddrx_cmd_fifo : synchronous command FIFO, no bypass, registered valid
// Revision      : 1.0  initial release
// ============================================================================
module ddrx_cmd_fifo
  import ddrx_mc_pkg::*;
#(
  parameter int  C_DEPTH = 8,
  parameter type T_ENTRY = cmd_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T_ENTRY                   push_data,
  input  logic                     pop,
  output T_ENTRY                   head,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(C_DEPTH):0] level
);

  localparam int C_PTR_W = $clog2(C_DEPTH);
  localparam int C_LVL_W = C_PTR_W + 1;

  T_ENTRY               r_mem [C_DEPTH];
  logic [C_PTR_W-1:0]   r_wr_ptr;
  logic [C_PTR_W-1:0]   r_rd_ptr;
  logic [C_LVL_W-1:0]   r_level;
  logic [C_LVL_W-1:0]   w_level_nxt;
  logic                 r_valid;
  logic                 w_pop;
  logic                 w_push;

  assign full   = (r_level == C_LVL_W'(C_DEPTH));
  assign w_pop  = pop && r_valid;
  assign w_push = push && (!full || w_pop);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + C_LVL_W'(1);
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - C_LVL_W'(1);
    end
  end

  // Storage is cleared too so head fields read as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      end
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != '0);
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign valid = r_valid;
  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/ddrx_port_arb.sv
`default_nettype none
// ============================================================================
// ddrx_port_arb : N-port RR / aged-priority command arbiter with output queue
// Revision      : 1.0  initial release
// ============================================================================
module ddrx_port_arb
  import ddrx_mc_pkg::*;
#(
  parameter int C_NUM_PORTS        = 4,
  parameter int C_NASTI_ID_WIDTH   = 4,
  parameter int C_NASTI_ADDR_WIDTH = 32,
  parameter int C_QUEUE_DEPTH      = 8,
  parameter int C_ARB_MODE         = 0,
  parameter int C_AGE_LIMIT        = 16
) (
  input  logic                                       core_clk,
  input  logic                                       core_arst,
  input  logic [C_NUM_PORTS-1:0]                     req_valid,
  output logic [C_NUM_PORTS-1:0]                     req_ready,
  input  logic [C_NUM_PORTS-1:0]                     req_write,
  input  logic [C_NUM_PORTS*C_NASTI_ADDR_WIDTH-1:0]  req_addr,
  input  logic [C_NUM_PORTS*C_NASTI_ID_WIDTH-1:0]    req_id,
  input  logic [C_NUM_PORTS*8-1:0]                   req_len,
  output logic                                       cmd_valid,
  input  logic                                       cmd_ready,
  output logic                                       cmd_write,
  output logic [C_NASTI_ADDR_WIDTH-1:0]              cmd_addr,
  output logic [C_NASTI_ID_WIDTH-1:0]                cmd_id,
  output logic [7:0]                                 cmd_len,
  output logic [$clog2(C_NUM_PORTS)-1:0]             cmd_port,
  output logic [$clog2(C_QUEUE_DEPTH):0]             queue_level
);

  localparam int C_PORT_W = $clog2(C_NUM_PORTS);
  localparam int C_AW     = C_NASTI_ADDR_WIDTH;
  localparam int C_IW     = C_NASTI_ID_WIDTH;

  typedef struct packed {
    logic                write;
    logic [C_AW-1:0]     addr;
    logic [C_IW-1:0]     id;
    logic [7:0]          len;
    logic [C_PORT_W-1:0] port;
  } entry_t;

  logic                   w_pop;
  logic                   w_push;
  logic                   w_push_ok;
  logic                   w_full;
  logic                   w_fifo_valid;
  logic [C_NUM_PORTS-1:0] w_pick;
  logic [C_NUM_PORTS-1:0] w_grant;
  entry_t                 w_push_data;
  entry_t                 w_head;

  // Rank 0 is the port right after the last winner; lowest rank wins.
  function automatic logic [C_NUM_PORTS-1:0] rr_pick(
    input logic [C_NUM_PORTS-1:0] valid,
    input logic [C_PORT_W-1:0]    last
  );
    logic [C_NUM_PORTS-1:0] pick;
    int                     best;
    int                     rank;
    pick = '0;
    best = C_NUM_PORTS;
    for (int i = 0; i < C_NUM_PORTS; i++) begin
      rank = (i + C_NUM_PORTS - 1 - int'(last)) % C_NUM_PORTS;
      if (valid[i] && (rank < best)) begin
        best    = rank;
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_pop     = w_fifo_valid && cmd_ready;
  assign w_push_ok = !w_full || w_pop;
  assign w_grant   = w_push_ok ? w_pick : '0;
  assign req_ready = w_grant & {C_NUM_PORTS{!core_arst}};
  assign w_push    = |(req_valid & req_ready);

  always_comb begin
    w_push_data = '0;
    for (int i = 0; i < C_NUM_PORTS; i++) begin
      if (w_grant[i]) begin
        w_push_data.write = req_write[i];
        w_push_data.addr  = req_addr[i*C_AW +: C_AW];
        w_push_data.id    = req_id[i*C_IW +: C_IW];
        w_push_data.len   = req_len[i*8 +: 8];
        w_push_data.port  = C_PORT_W'(i);
      end
    end
  end

  if (C_ARB_MODE == int'(ARB_AGED)) begin : g_aged
    localparam int C_AGE_W = $clog2(C_AGE_LIMIT + 1);

    logic [C_AGE_W-1:0]     r_age [C_NUM_PORTS];
    logic [C_NUM_PORTS-1:0] w_aged;

    always_comb begin
      w_aged = '0;
      for (int i = 0; i < C_NUM_PORTS; i++) begin
        w_aged[i] = req_valid[i] && (r_age[i] == C_AGE_W'(C_AGE_LIMIT));
      end
    end

    // Lowest set bit: aged ports first, otherwise plain fixed priority.
    assign w_pick = (|w_aged) ? (w_aged & (~w_aged + C_NUM_PORTS'(1)))
                              : (req_valid & (~req_valid + C_NUM_PORTS'(1)));

    always_ff @(posedge core_clk or posedge core_arst) begin
      if (core_arst) begin
        for (int i = 0; i < C_NUM_PORTS; i++) begin
          r_age[i] <= '0;
        end
      end else begin
        for (int i = 0; i < C_NUM_PORTS; i++) begin
          if (!req_valid[i] || w_grant[i]) begin
            r_age[i] <= '0;
          end else if (r_age[i] != C_AGE_W'(C_AGE_LIMIT)) begin
            r_age[i] <= r_age[i] + C_AGE_W'(1);
          end
        end
      end
    end
  end else begin : g_rr
    logic [C_PORT_W-1:0] r_rr_ptr;

    assign w_pick = rr_pick(req_valid, r_rr_ptr);

    always_ff @(posedge core_clk or posedge core_arst) begin
      if (core_arst) begin
        r_rr_ptr <= C_PORT_W'(C_NUM_PORTS - 1);
      end else if (w_push) begin
        r_rr_ptr <= w_push_data.port;
      end
    end
  end

  ddrx_cmd_fifo #(
    .C_DEPTH (C_QUEUE_DEPTH),
    .T_ENTRY (entry_t)
  ) u_cmd_fifo (
    .clk       (core_clk),
    .rst       (core_arst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .valid     (w_fifo_valid),
    .full      (w_full),
    .level     (queue_level)
  );

  assign cmd_valid = w_fifo_valid;
  assign cmd_write = w_head.write;
  assign cmd_addr  = w_head.addr;
  assign cmd_id    = w_head.id;
  assign cmd_len   = w_head.len;
  assign cmd_port  = w_head.port;

endmodule
`default_nettype wire

// File: tb/tb_ddrx_port_arb.sv
`default_nettype none
// ============================================================================
// tb_ddrx_port_arb : random-stimulus bench, RR and aged instances vs. model
// Revision         : 1.0  initial release
// ============================================================================
module tb_ddrx_port_arb;

  localparam int NP    = 4;
  localparam int AW    = 32;
  localparam int IW    = 4;
  localparam int DEPTH = 8;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [7:0]    len;
    logic [1:0]    port;
  } ent_t;

  logic             core_clk = 1'b0;
  logic             core_arst;
  logic [NP-1:0]    req_valid;
  logic [NP-1:0]    req_write;
  logic [NP*AW-1:0] req_addr;
  logic [NP*IW-1:0] req_id;
  logic [NP*8-1:0]  req_len;
  logic             cmd_ready;

  logic [NP-1:0] rr_ready, ag_ready;
  logic          rr_cvalid, ag_cvalid, rr_cwrite, ag_cwrite;
  logic [AW-1:0] rr_caddr, ag_caddr;
  logic [IW-1:0] rr_cid, ag_cid;
  logic [7:0]    rr_clen, ag_clen;
  logic [1:0]    rr_cport, ag_cport;
  logic [3:0]    rr_level, ag_level;

  ent_t q_rr[$];
  ent_t q_ag[$];
  int   rr_last;
  int   age_m [NP];
  int   n_tests;
  int   n_fail;

  always #5 core_clk = ~core_clk;

  ddrx_port_arb #(
    .C_NUM_PORTS(NP), .C_NASTI_ID_WIDTH(IW), .C_NASTI_ADDR_WIDTH(AW),
    .C_QUEUE_DEPTH(DEPTH), .C_ARB_MODE(0), .C_AGE_LIMIT(16)
  ) u_rr (
    .core_clk(core_clk), .core_arst(core_arst), .req_valid(req_valid),
    .req_ready(rr_ready), .req_write(req_write), .req_addr(req_addr),
    .req_id(req_id), .req_len(req_len), .cmd_valid(rr_cvalid),
    .cmd_ready(cmd_ready), .cmd_write(rr_cwrite), .cmd_addr(rr_caddr),
    .cmd_id(rr_cid), .cmd_len(rr_clen), .cmd_port(rr_cport),
    .queue_level(rr_level)
  );

  ddrx_port_arb #(
    .C_NUM_PORTS(NP), .C_NASTI_ID_WIDTH(IW), .C_NASTI_ADDR_WIDTH(AW),
    .C_QUEUE_DEPTH(DEPTH), .C_ARB_MODE(1), .C_AGE_LIMIT(LIMIT)
  ) u_ag (
    .core_clk(core_clk), .core_arst(core_arst), .req_valid(req_valid),
    .req_ready(ag_ready), .req_write(req_write), .req_addr(req_addr),
    .req_id(req_id), .req_len(req_len), .cmd_valid(ag_cvalid),
    .cmd_ready(cmd_ready), .cmd_write(ag_cwrite), .cmd_addr(ag_caddr),
    .cmd_id(ag_cid), .cmd_len(ag_clen), .cmd_port(ag_cport),
    .queue_level(ag_level)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next valid port after the previous winner, wrapping around.
  function automatic int pick_rr(input logic [NP-1:0] v, input int last);
    for (int k = 1; k <= NP; k++) begin
      if (v[(last + k) % NP]) return (last + k) % NP;
    end
    return -1;
  endfunction

  function automatic int pick_aged(input logic [NP-1:0] v);
    for (int i = 0; i < NP; i++) begin
      if (v[i] && age_m[i] == LIMIT) return i;
    end
    for (int i = 0; i < NP; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic ent_t mk_ent(input int p);
    ent_t e;
    e.write = req_write[p];
    e.addr  = req_addr[p*AW +: AW];
    e.id    = req_id[p*IW +: IW];
    e.len   = req_len[p*8 +: 8];
    e.port  = 2'(p);
    return e;
  endfunction

  task automatic check_side(input string s, input ent_t q[$], input int g,
                            input logic [NP-1:0] rdy, input logic cv, input logic [3:0] lvl,
                            input logic cw, input logic [AW-1:0] ca, input logic [IW-1:0] ci,
                            input logic [7:0] cl, input logic [1:0] cp);
    logic [NP-1:0] e_rdy;
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    check({s, ".req_ready"},   64'(rdy), 64'(e_rdy));
    check({s, ".cmd_valid"},   64'(cv),  64'(q.size() != 0));
    check({s, ".queue_level"}, 64'(lvl), 64'(q.size()));
    if (q.size() != 0) begin
      check({s, ".cmd_write"}, 64'(cw), 64'(q[0].write));
      check({s, ".cmd_addr"},  64'(ca), 64'(q[0].addr));
      check({s, ".cmd_id"},    64'(ci), 64'(q[0].id));
      check({s, ".cmd_len"},   64'(cl), 64'(q[0].len));
      check({s, ".cmd_port"},  64'(cp), 64'(q[0].port));
    end
  endtask

  // One clock: drive at edge+1, check at edge+2, advance model at the edge.
  task automatic step(input logic [NP-1:0] mask, input int pv, input int pr);
    int g_rr, g_ag;
    bit pop_rr, pop_ag;
    for (int i = 0; i < NP; i++) begin
      req_valid[i]          = mask[i] && ($urandom_range(0, 99) < pv);
      req_write[i]          = 1'($urandom);
      req_addr[i*AW +: AW]  = $urandom;
      req_id[i*IW +: IW]    = IW'($urandom);
      req_len[i*8 +: 8]     = 8'($urandom);
    end
    cmd_ready = ($urandom_range(0, 99) < pr);
    #1;
    pop_rr = (q_rr.size() != 0) && cmd_ready;
    pop_ag = (q_ag.size() != 0) && cmd_ready;
    g_rr = (q_rr.size() < DEPTH || pop_rr) ? pick_rr(req_valid, rr_last) : -1;
    g_ag = (q_ag.size() < DEPTH || pop_ag) ? pick_aged(req_valid) : -1;
    check_side("rr", q_rr, g_rr, rr_ready, rr_cvalid, rr_level, rr_cwrite,
               rr_caddr, rr_cid, rr_clen, rr_cport);
    check_side("ag", q_ag, g_ag, ag_ready, ag_cvalid, ag_level, ag_cwrite,
               ag_caddr, ag_cid, ag_clen, ag_cport);
    @(posedge core_clk);
    if (pop_rr) void'(q_rr.pop_front());
    if (pop_ag) void'(q_ag.pop_front());
    if (g_rr >= 0) begin
      q_rr.push_back(mk_ent(g_rr));
      rr_last = g_rr;
    end
    if (g_ag >= 0) q_ag.push_back(mk_ent(g_ag));
    for (int i = 0; i < NP; i++) begin
      if (!req_valid[i] || i == g_ag) age_m[i] = 0;
      else if (age_m[i] < LIMIT) age_m[i]++;
    end
    #1;
  endtask

  task automatic model_reset();
    q_rr.delete();
    q_ag.delete();
    rr_last = NP - 1;
    for (int i = 0; i < NP; i++) age_m[i] = 0;
  endtask

  task automatic do_reset_mid();
    req_valid = '1;
    #1;
    core_arst = 1'b1;
    #1;
    check("rst_mid.rr_ready",  64'(rr_ready),  64'd0);
    check("rst_mid.ag_ready",  64'(ag_ready),  64'd0);
    check("rst_mid.rr_cvalid", 64'(rr_cvalid), 64'd0);
    check("rst_mid.ag_cvalid", 64'(ag_cvalid), 64'd0);
    check("rst_mid.rr_level",  64'(rr_level),  64'd0);
    check("rst_mid.ag_level",  64'(ag_level),  64'd0);
    @(posedge core_clk);
    #1;
    core_arst = 1'b0;
    model_reset();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    model_reset();
    core_arst = 1'b1;
    req_valid = '1;
    req_write = '1;
    req_addr  = '1;
    req_id    = '1;
    req_len   = '1;
    cmd_ready = 1'b1;
    @(posedge core_clk);
    #1;
    check("rst.rr_ready",  64'(rr_ready),  64'd0);
    check("rst.ag_ready",  64'(ag_ready),  64'd0);
    check("rst.rr_cvalid", 64'(rr_cvalid), 64'd0);
    check("rst.ag_cvalid", 64'(ag_cvalid), 64'd0);
    check("rst.rr_level",  64'(rr_level),  64'd0);
    check("rst.rr_fields", 64'({rr_cwrite, rr_caddr, rr_cid, rr_clen, rr_cport}), 64'd0);
    check("rst.ag_fields", 64'({ag_cwrite, ag_caddr, ag_cid, ag_clen, ag_cport}), 64'd0);
    @(posedge core_clk);
    #1;
    core_arst = 1'b0;

    repeat (12)  step(4'b1111, 100, 100);
    repeat (12)  step(4'b0100, 100, 0);
    repeat (4)   step(4'b0100, 100, 100);
    repeat (10)  step(4'b1010, 100, 100);
    repeat (20)  step(4'b1001, 100, 100);
    repeat (15)  step(4'b1111, 100, 0);
    repeat (300) step(4'b1111, 50, 50);
    repeat (200) step(4'b1111, 80, 25);
    repeat (200) step(4'b1111, 30, 90);
    repeat (5)   step(4'b1111, 100, 0);
    do_reset_mid();
    repeat (20)  step(4'b1111, 100, 100);
    repeat (100) step(4'b1111, 60, 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
